// File: rtl/bcd_pkg.sv
// Shared encodings for the BCD counter controller: command opcodes, FSM states
// and a small helper to validate a packed BCD nibble.
package bcd_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } bcd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } bcd_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd_nibble(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0-9) with synchronous load and a single up/down step per
// enabled cycle; carry flags the 9->0 (up) or 0->9 (down) roll.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       up,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_en) begin
      digit_d = load_val;
    end else if (step_en) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = step_en & (up ? (digit_q == BCD_MAX) : (digit_q == 4'd0));

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command-driven two-digit BCD counter: LOAD/CLEAR complete in one cycle,
// UP/DOWN step once per cycle in RUN, with wrap or saturation at 99/00.
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
// cmd_ready is high only in IDLE, and cmd_op/cmd_arg are sampled only on that edge.
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int WRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic       abort,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       tc,
  output logic       err,
  output logic [1:0] state_dbg
);

  bcd_state_e state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic       dir_up_q, dir_up_d;
  logic       done_q, done_d;
  logic       tc_q, tc_d;
  logic       err_q, err_d;

  logic       load_en;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       step_en;
  logic       ones_carry;
  logic       tens_carry;
  logic       at_term;

  // A step from here would cross 99->00 or 00->99.
  assign at_term = dir_up_q ? ((tens == BCD_MAX) && (ones == BCD_MAX))
                            : ((tens == 4'd0) && (ones == 4'd0));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_up_d    = dir_up_q;
    done_d      = 1'b0;
    tc_d        = 1'b0;
    err_d       = 1'b0;
    load_en     = 1'b0;
    load_tens   = cmd_arg[7:4];
    load_ones   = cmd_arg[3:0];
    step_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (bcd_op_e'(cmd_op))
            OP_LOAD: begin
              if (is_bcd_nibble(cmd_arg[7:4]) && is_bcd_nibble(cmd_arg[3:0])) begin
                load_en = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
            OP_CLEAR: begin
              load_en   = 1'b1;
              load_tens = 4'd0;
              load_ones = 4'd0;
              state_d   = ST_DONE;
              done_d    = 1'b1;
            end
            default: begin
              if (cmd_arg == 8'd0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                remaining_d = cmd_arg;
                dir_up_d    = (bcd_op_e'(cmd_op) == OP_UP);
                state_d     = ST_RUN;
              end
            end
          endcase
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Abort takes priority over any step, including a terminal one.
          remaining_d = 8'd0;
          state_d     = ST_DONE;
          done_d      = 1'b1;
        end else if (at_term && (WRAP == 0)) begin
          remaining_d = 8'd0;
          tc_d        = 1'b1;
          state_d     = ST_DONE;
          done_d      = 1'b1;
        end else begin
          step_en     = 1'b1;
          tc_d        = at_term;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      dir_up_q    <= 1'b0;
      done_q      <= 1'b0;
      tc_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_up_q    <= dir_up_d;
      done_q      <= done_d;
      tc_q        <= tc_d;
      err_q       <= err_d;
    end
  end

  bcd_digit u_ones (
    .clk      (clk),
    .rst      (rst),
    .step_en  (step_en),
    .up       (dir_up_q),
    .load_en  (load_en),
    .load_val (load_ones),
    .digit    (ones),
    .carry    (ones_carry)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst      (rst),
    .step_en  (ones_carry),
    .up       (dir_up_q),
    .load_en  (load_en),
    .load_val (load_tens),
    .digit    (tens),
    .carry    (tens_carry)
  );

  // The tens roll-over is already covered by at_term; it has no further use.
  logic unused_carry;
  assign unused_carry = tens_carry;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign tc        = tc_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/bcd_count_ctrl.md
BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

Interface
REQ-001 Parameter WRAP, default 1, meaning 1 = wrap 99<->00, 0 = saturate at 99/00.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  controller accepts command this cycle.
REQ-006 cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-007 cmd_arg  input  8  LOAD: packed BCD {tens,ones}; UP/DOWN: unsigned binary step count 0-255; CLEAR: ignored.
REQ-008 abort  input  1  synchronous stop of a running UP/DOWN command.
REQ-009 tens  output  4  BCD tens digit.
REQ-010 ones  output  4  BCD ones digit.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse, command complete.
REQ-013 tc  output  1  one-cycle pulse, terminal count hit (wrap or saturation).
REQ-014 err  output  1  one-cycle pulse coincident with done, LOAD rejected.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid & cmd_ready; cmd_op/cmd_arg are sampled only then.
REQ-017 LOAD with both nibbles <= 9: tens/ones update on the accepting edge; state -> DONE.
REQ-018 LOAD with either nibble > 9: digits unchanged; state -> DONE; err = 1 during the DONE cycle.
REQ-019 CLEAR: tens/ones = 0/0 on the accepting edge; state -> DONE.
REQ-020 UP/DOWN with cmd_arg = 0: no step; state -> DONE.
REQ-021 UP/DOWN with cmd_arg = N > 0: latch N into an 8-bit remaining counter and direction; state -> RUN.
REQ-022 In RUN, each edge SHALL perform exactly one BCD step (ones +/-1, carry/borrow into tens) and decrement remaining; after the Nth step, state -> DONE.
REQ-023 Latency: done is high N+1 cycles after the accepting edge for UP/DOWN, 1 cycle for LOAD/CLEAR/N=0.
REQ-024 Step arithmetic: up 09->10, 99->00 (WRAP=1); down 10->09, 00->99 (WRAP=1); digits never leave 0-9.
REQ-025 WRAP=1: any step crossing 99->00 or 00->99 SHALL pulse tc in the following cycle; counting continues.
REQ-026 WRAP=0: a step attempted at 99 (up) or 00 (down) SHALL leave digits unchanged, pulse tc in the following cycle, clear remaining, and go to DONE (early completion).
REQ-027 abort sampled high in RUN: no step that edge, remaining cleared, state -> DONE; abort ignored in IDLE/DONE.
REQ-028 DONE SHALL last exactly one cycle (done = 1), then -> IDLE; back-to-back commands have a minimum spacing of 2 cycles.
REQ-029 If abort and a terminal step coincide, abort wins: no step, no tc.

Reset
REQ-030 rst low SHALL immediately force state IDLE, tens = 0, ones = 0, remaining = 0, done = tc = err = 0, busy = 0, cmd_ready = 1 (after release).
REQ-031 Reset mid-RUN SHALL discard the command with no done pulse.

Structure
REQ-032 Opcode encodings and FSM state encodings SHALL live in a shared package (bcd_pkg).
REQ-033 One sub-module bcd_digit (4-bit BCD digit, inputs step_en, up, rst; outputs digit, carry/borrow-out at 9->0 / 0->9) SHALL be instantiated twice, ones chained into tens.
REQ-034 All registers are on posedge clk / negedge rst; done, tc, err are registered outputs.

Verification
REQ-035 Reset, then LOAD 0x47 -> tens/ones = 4/7 on accept edge, done one cycle later, err = 0.
REQ-036 LOAD 0x3A -> digits unchanged, done & err pulse together.
REQ-037 From 0x97, UP 5 (WRAP=1) -> sequence 98,99,00,01,02; tc one cycle after 99->00; done at cycle 6.
REQ-038 From 0x02, DOWN 5 (WRAP=0) -> 01,00, stop; tc pulse, done early, final 00.
REQ-039 From 0x10, DOWN 200, abort after 3 steps -> final 07, done next cycle, tc = 0.
REQ-040 Assert rst mid-RUN of UP 50 -> digits 00 immediately, no done; next LOAD accepted normally.
